// File: rtl/link_ber_monitor_if.sv
// Bundles the stimulus and readout signals of link_ber_monitor.
// The master drives the bit stream and controls, and the slave returns the measurement.
interface link_ber_monitor_if #(
    parameter int CAP_W = 8,
    parameter int LAT_W = 7,
    parameter int CNT_W = 16
);
    logic             start;
    logic             bit_en;
    logic             tx_bit;
    logic             rx_bit;
    logic [LAT_W-1:0] latency;
    logic             locked;
    logic             done;
    logic [CAP_W-1:0] capture;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;
    logic [2:0]       state;

    modport master (
        output start, bit_en, tx_bit, rx_bit, latency,
        input  locked, done, capture, err_count, bit_count, state
    );

    modport slave (
        input  start, bit_en, tx_bit, rx_bit, latency,
        output locked, done, capture, err_count, bit_count, state
    );
endinterface

// File: rtl/link_ber_monitor.sv
// Link BER monitor. It delays tx by a programmable latency and lets the link settle.
// It then hunts for alignment, captures an rx snapshot and counts bit errors over a fixed window.
module link_ber_monitor #(
    parameter int CAP_W       = 8,
    parameter int LOCK_THRESH = 6,
    parameter int SETTLE_BITS = 80,
    parameter int MAX_LAT     = 64,
    parameter int LAT_W       = 7,
    parameter int HUNT_MAX    = 1024,
    parameter int WIN_BITS    = 4096,
    parameter int CNT_W       = 16
) (
    input  logic           clk,
    input  logic           reset,
    link_ber_monitor_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_HUNT    = 3'd2,
        S_MEASURE = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    localparam int FILL_W = $clog2(CAP_W + 1);
    localparam int PH_MAX = (SETTLE_BITS > HUNT_MAX)
                          ? ((SETTLE_BITS > WIN_BITS) ? SETTLE_BITS : WIN_BITS)
                          : ((HUNT_MAX > WIN_BITS) ? HUNT_MAX : WIN_BITS);
    localparam int PH_W   = $clog2(PH_MAX + 1);

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [MAX_LAT-1:0] dly_q, dly_d;
    logic [CAP_W-1:0]   rx_win_q, rx_win_d;
    logic [CAP_W-1:0]   ref_win_q, ref_win_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PH_W-1:0]    cnt_q, cnt_d;
    logic               locked_q, locked_d;
    logic               done_q, done_d;
    logic [CAP_W-1:0]   capture_q, capture_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   bits_q, bits_d;

    logic               ref_bit;
    logic [LAT_W-1:0]   lat_clamp;
    logic [CAP_W-1:0]   rx_win_sh, ref_win_sh;
    logic [FILL_W-1:0]  fill_sh;
    logic [FILL_W-1:0]  mism;
    logic               lock_ok;

    // Reference is tx as it was lat_q strobes ago; a latency of zero means tx itself.
    always_comb begin
        ref_bit = bus.tx_bit;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (lat_q == LAT_W'(i + 1)) ref_bit = dly_q[i];
        end
    end

    assign lat_clamp  = (bus.latency > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : bus.latency;
    assign rx_win_sh  = {rx_win_q[CAP_W-2:0], bus.rx_bit};
    assign ref_win_sh = {ref_win_q[CAP_W-2:0], ref_bit};
    assign fill_sh    = (fill_q == FILL_W'(CAP_W)) ? fill_q : fill_q + FILL_W'(1);

    always_comb begin
        mism = '0;
        for (int i = 0; i < CAP_W; i++) begin
            mism = mism + FILL_W'(rx_win_sh[i] ^ ref_win_sh[i]);
        end
    end

    assign lock_ok = (fill_sh == FILL_W'(CAP_W)) && (mism <= FILL_W'(CAP_W - LOCK_THRESH));

    always_comb begin
        // NOTE: every next-state signal is defaulted to its register first, so no path can infer a latch.
        state_d   = state_q;
        lat_d     = lat_q;
        dly_d     = dly_q;
        rx_win_d  = rx_win_q;
        ref_win_d = ref_win_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        locked_d  = locked_q;
        done_d    = done_q;
        capture_d = capture_q;
        err_d     = err_q;
        bits_d    = bits_q;

        if (bus.start) begin
            // A strobe arriving together with start is dropped, and the delay line keeps its history.
            state_d   = S_SETTLE;
            lat_d     = lat_clamp;
            cnt_d     = '0;
            locked_d  = 1'b0;
            done_d    = 1'b0;
            capture_d = '0;
            err_d     = '0;
            bits_d    = '0;
        end else if (bus.bit_en && state_q != S_IDLE) begin
            dly_d = {dly_q[MAX_LAT-2:0], bus.tx_bit};
            unique case (state_q)
                S_SETTLE: begin
                    cnt_d = cnt_q + PH_W'(1);
                    if (cnt_q == PH_W'(SETTLE_BITS - 1)) begin
                        state_d   = S_HUNT;
                        cnt_d     = '0;
                        rx_win_d  = '0;
                        ref_win_d = '0;
                        fill_d    = '0;
                    end
                end
                S_HUNT: begin
                    rx_win_d  = rx_win_sh;
                    ref_win_d = ref_win_sh;
                    fill_d    = fill_sh;
                    cnt_d     = cnt_q + PH_W'(1);
                    if (lock_ok) begin
                        state_d   = S_MEASURE;
                        locked_d  = 1'b1;
                        capture_d = rx_win_sh;
                        cnt_d     = '0;
                    end else if (cnt_q + PH_W'(1) == PH_W'(HUNT_MAX)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
                S_MEASURE: begin
                    cnt_d  = cnt_q + PH_W'(1);
                    bits_d = (bits_q == '1) ? bits_q : bits_q + CNT_W'(1);
                    if (bus.rx_bit != ref_bit && err_q != '1) err_d = err_q + CNT_W'(1);
                    // Window length is tracked by cnt_q so a narrow bit_count can saturate harmlessly.
                    if (cnt_q + PH_W'(1) == PH_W'(WIN_BITS)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            lat_q     <= '0;
            // NOTE: the delay line is cleared on reset so that the reference before the line fills is a defined zero.
            dly_q     <= '0;
            rx_win_q  <= '0;
            ref_win_q <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            locked_q  <= 1'b0;
            done_q    <= 1'b0;
            capture_q <= '0;
            err_q     <= '0;
            bits_q    <= '0;
        end else begin
            // NOTE: registers use non-blocking assignment so that all of them update together at the edge.
            state_q   <= state_d;
            lat_q     <= lat_d;
            dly_q     <= dly_d;
            rx_win_q  <= rx_win_d;
            ref_win_q <= ref_win_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            locked_q  <= locked_d;
            done_q    <= done_d;
            capture_q <= capture_d;
            err_q     <= err_d;
            bits_q    <= bits_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.locked    = locked_q;
    assign bus.done      = done_q;
    assign bus.capture   = capture_q;
    assign bus.err_count = err_q;
    assign bus.bit_count = bits_q;

endmodule

// File: tb/tb_link_ber_monitor.sv
// Randomised scoreboard bench for link_ber_monitor: a full-size instance and a narrow-counter instance.
// A whole-run reference model predicts each run's result, and the monitors compare it when done rises.
module tb_link_ber_monitor;

    localparam int CAP = 8;
    localparam int TH  = 6;
    localparam int M_PRBS = 0, M_FLIP = 1, M_ALT = 2, M_INV = 3;

    typedef struct {
        bit locked;
        int capture;
        int err;
        int bits;
        int used;
    } exp_t;

    int settle_p [2] = '{80, 4};
    int hunt_p   [2] = '{1024, 16};
    int win_p    [2] = '{4096, 32};
    int cmax_p   [2] = '{65535, 15};
    int maxl_p   [2] = '{64, 8};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    link_ber_monitor_if #(.CAP_W(8), .LAT_W(7), .CNT_W(16)) bus0 ();
    link_ber_monitor_if #(.CAP_W(8), .LAT_W(4), .CNT_W(4))  bus1 ();

    link_ber_monitor #(.CAP_W(8), .LOCK_THRESH(6), .SETTLE_BITS(80), .MAX_LAT(64), .LAT_W(7),
                       .HUNT_MAX(1024), .WIN_BITS(4096), .CNT_W(16))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));

    link_ber_monitor #(.CAP_W(8), .LOCK_THRESH(6), .SETTLE_BITS(4), .MAX_LAT(8), .LAT_W(4),
                       .HUNT_MAX(16), .WIN_BITS(32), .CNT_W(4))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    bit   hist0[$];
    bit   hist1[$];

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-run prediction: find the first full hunt window with enough agreement, then count mismatches over the next WIN bits.
    function automatic exp_t model(bit h[$], bit tx[$], bit rx[$], int lat, int inst);
        bit   full[$];
        bit   refb[$];
        exp_t e;
        int   base, lockj, settle, st, errs;
        settle = settle_p[inst];
        if (lat > maxl_p[inst]) lat = maxl_p[inst];
        full = h;
        base = h.size();
        foreach (tx[i]) full.push_back(tx[i]);
        foreach (tx[i]) refb.push_back((base + i - lat >= 0) ? full[base + i - lat] : 1'b0);
        lockj = -1;
        for (int j = CAP - 1; j < hunt_p[inst] && lockj < 0; j++) begin
            int m = 0;
            for (int k = 0; k < CAP; k++) if (rx[settle + j - k] == refb[settle + j - k]) m++;
            if (m >= TH) lockj = j;
        end
        e = '{default: 0};
        if (lockj < 0) begin
            e.used = settle + hunt_p[inst];
        end else begin
            e.locked = 1'b1;
            for (int k = 0; k < CAP; k++) if (rx[settle + lockj - k]) e.capture |= (1 << k);
            st   = settle + lockj + 1;
            errs = 0;
            for (int i = 0; i < win_p[inst]; i++) if (rx[st + i] != refb[st + i]) errs++;
            e.err  = (errs > cmax_p[inst]) ? cmax_p[inst] : errs;
            e.bits = (win_p[inst] > cmax_p[inst]) ? cmax_p[inst] : win_p[inst];
            e.used = st + win_p[inst];
        end
        return e;
    endfunction

    task automatic gen(int mode, int d, int inst, bit h[$], output bit tx_o[$], output bit rx_o[$]);
        bit full[$];
        bit tx[$];
        bit rx[$];
        int base, n, settle;
        bit t, r;
        settle = settle_p[inst];
        n      = settle + hunt_p[inst] + win_p[inst];
        full   = h;
        base   = h.size();
        for (int i = 0; i < n; i++) begin
            t = (mode == M_ALT) ? bit'(i % 2) : bit'($urandom_range(0, 1));
            tx.push_back(t);
            full.push_back(t);
        end
        for (int i = 0; i < n; i++) begin
            r = (base + i - d >= 0) ? full[base + i - d] : 1'b0;
            if (mode == M_ALT) r = 1'b0;
            if (mode == M_FLIP && (i == settle + 1 || i == settle + 4 ||
                (i >= settle + CAP && (i - settle - CAP) % 64 == 0))) r = ~r;
            if (mode == M_INV && i >= settle + CAP) r = ~r;
            rx.push_back(r);
        end
        tx_o = tx;
        rx_o = rx;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int inst, bit st, bit en, bit tx, bit rx);
        if (inst == 0) begin
            bus0.start = st; bus0.bit_en = en; bus0.tx_bit = tx; bus0.rx_bit = rx;
        end else begin
            bus1.start = st; bus1.bit_en = en; bus1.tx_bit = tx; bus1.rx_bit = rx;
        end
    endtask

    task automatic start_pulse(int inst, int lat, bit with_bit, bit tx);
        if (inst == 0) bus0.latency = 7'(lat);
        else           bus1.latency = 4'(lat);
        drive(inst, 1'b1, with_bit, tx, 1'b0);
        cycle();
        drive(inst, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bits(int inst, bit tx[$], bit rx[$], int from, int to, int gapmax);
        for (int i = from; i < to; i++) begin
            drive(inst, 1'b0, 1'b1, tx[i], rx[i]);
            cycle();
            drive(inst, 1'b0, 1'b0, 1'b0, 1'b0);
            if (inst == 0) hist0.push_back(tx[i]);
            else           hist1.push_back(tx[i]);
            if (gapmax > 0) repeat ($urandom_range(1, gapmax)) cycle();
        end
    endtask

    task automatic run(int inst, int mode, int d, int lat, int gapmax);
        bit   tx[$];
        bit   rx[$];
        bit   h[$];
        exp_t e;
        if (inst == 0) h = hist0; else h = hist1;
        gen(mode, d, inst, h, tx, rx);
        e = model(h, tx, rx, lat, inst);
        if (inst == 0) sb0.push_back(e); else sb1.push_back(e);
        start_pulse(inst, lat, 1'b0, 1'b0);
        send_bits(inst, tx, rx, 0, e.used, gapmax);
        for (int c = 0; c < 20 && ((inst == 0) ? sb0.size() : sb1.size()) != 0; c++) cycle();
        if (inst == 0 && sb0.size() != 0) begin
            check("dut0 done timeout", int'(bus0.done), 1);
            void'(sb0.pop_front());
        end
        if (inst == 1 && sb1.size() != 0) begin
            check("dut1 done timeout", int'(bus1.done), 1);
            void'(sb1.pop_front());
        end
    endtask

    task automatic compare(int inst, exp_t e);
        if (inst == 0) begin
            check("dut0 state", int'(bus0.state), 4);
            check("dut0 locked", int'(bus0.locked), int'(e.locked));
            check("dut0 capture", int'(bus0.capture), e.capture);
            check("dut0 err_count", int'(bus0.err_count), e.err);
            check("dut0 bit_count", int'(bus0.bit_count), e.bits);
        end else begin
            check("dut1 state", int'(bus1.state), 4);
            check("dut1 locked", int'(bus1.locked), int'(e.locked));
            check("dut1 capture", int'(bus1.capture), e.capture);
            check("dut1 err_count", int'(bus1.err_count), e.err);
            check("dut1 bit_count", int'(bus1.bit_count), e.bits);
        end
    endtask

    bit   done_prev0 = 1'b0;
    bit   done_prev1 = 1'b0;
    exp_t me0, me1;

    always @(negedge clk) begin
        if (bus0.done && !done_prev0) begin
            if (sb0.size() == 0) check("dut0 unexpected done", int'(bus0.done), 0);
            else begin
                me0 = sb0.pop_front();
                compare(0, me0);
            end
        end
        done_prev0 = bus0.done;
    end

    always @(negedge clk) begin
        if (bus1.done && !done_prev1) begin
            if (sb1.size() == 0) check("dut1 unexpected done", int'(bus1.done), 0);
            else begin
                me1 = sb1.pop_front();
                compare(1, me1);
            end
        end
        done_prev1 = bus1.done;
    end

    task automatic check_cleared(string tag);
        check({tag, " state"}, int'(bus0.state), 0);
        check({tag, " locked"}, int'(bus0.locked), 0);
        check({tag, " done"}, int'(bus0.done), 0);
        check({tag, " capture"}, int'(bus0.capture), 0);
        check({tag, " err_count"}, int'(bus0.err_count), 0);
        check({tag, " bit_count"}, int'(bus0.bit_count), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit tx[$];
        bit rx[$];
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus0.latency = '0;
        bus1.latency = '0;
        repeat (3) cycle();
        reset = 1'b0;
        @(negedge clk);
        check_cleared("reset");
        check("reset dut1 state", int'(bus1.state), 0);

        // Loopback, then strobes in DONE must leave the result untouched.
        run(0, M_PRBS, 0, 0, 0);
        gen(M_PRBS, 0, 0, hist0, tx, rx);
        send_bits(0, tx, rx, 0, 5, 0);
        @(negedge clk);
        check("done hold state", int'(bus0.state), 4);
        check("done hold bit_count", int'(bus0.bit_count), 4096);
        check("done hold locked", int'(bus0.locked), 1);

        // Restart mid-MEASURE with a coincident strobe, then reset mid-HUNT together with start.
        gen(M_PRBS, 0, 0, hist0, tx, rx);
        start_pulse(0, 0, 1'b0, 1'b0);
        send_bits(0, tx, rx, 0, 80 + CAP + 10, 0);
        @(negedge clk);
        check("mid measure state", int'(bus0.state), 3);
        check("mid measure bit_count", int'(bus0.bit_count), 10);
        start_pulse(0, 0, 1'b1, 1'b1);
        @(negedge clk);
        check("restart state", int'(bus0.state), 1);
        check("restart bit_count", int'(bus0.bit_count), 0);
        check("restart locked", int'(bus0.locked), 0);
        check("restart capture", int'(bus0.capture), 0);
        send_bits(0, tx, rx, 100, 179, 0);
        @(negedge clk);
        check("settle 79 strobes state", int'(bus0.state), 1);
        send_bits(0, tx, rx, 179, 180, 0);
        @(negedge clk);
        check("settle 80 strobes state", int'(bus0.state), 2);
        send_bits(0, tx, rx, 180, 183, 0);
        bus0.start = 1'b1;
        reset      = 1'b1;
        cycle();
        bus0.start = 1'b0;
        reset      = 1'b0;
        hist0.delete();
        hist1.delete();
        @(negedge clk);
        check_cleared("mid hunt reset");

        run(0, M_PRBS, 37, 37, 0);
        run(0, M_PRBS, 37, 36, 0);
        run(0, M_FLIP, 0, 0, 0);
        run(0, M_ALT, 0, 0, 0);
        run(0, M_PRBS, 64, 100, 0);
        run(0, M_PRBS, 0, 0, 3);

        // Narrow counters: all MEASURE bits wrong saturates err_count, with long and no strobe gaps.
        run(1, M_INV, 0, 0, 200);
        run(1, M_INV, 0, 0, 0);
        run(1, M_PRBS, 5, 5, 0);
        run(1, M_PRBS, 8, 12, 2);

        repeat (5) cycle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
